// File: rtl/reset_sequencer.sv
// Reset sequencer: holds peripheral and core resets, then releases peripherals before the core.
// Optional cause register is enabled by defining RESET_SEQUENCER_CAUSE_EN.
module reset_sequencer #(
   parameter int unsigned HOLD_CYCLES    = 16,
   parameter int unsigned STAGGER_CYCLES = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sw_req_i,
   input  logic       ext_req_i,
   output logic       rst_periph_no,
   output logic       rst_core_no,
   output logic       busy_o,
   output logic [1:0] rst_cause_o
);

   localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] STAG_LD  = CW'(STAGGER_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      HOLD,
      STAGGER,
      RUN
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          req;

   assign req = sw_req_i | ext_req_i;

   // Any request restarts the hold from a full count, whatever the current state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (req) begin
         state_nxt = HOLD;
         cnt_nxt   = HOLD_LD;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == CNT_ONE) begin
                  state_nxt = STAGGER;
                  cnt_nxt   = STAG_LD;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
            STAGGER: begin
               if (cnt == CNT_ONE) begin
                  state_nxt = RUN;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
            RUN: begin
               state_nxt = RUN;
            end
            default: begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LD;
            end
         endcase
      end
   end

   // Outputs are registered from the next-state decode so they come straight from flops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= HOLD;
         cnt           <= HOLD_LD;
         rst_periph_no <= 1'b0;
         rst_core_no   <= 1'b0;
         busy_o        <= 1'b1;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         rst_periph_no <= (state_nxt != HOLD);
         rst_core_no   <= (state_nxt == RUN);
         busy_o        <= (state_nxt != RUN);
      end
   end

`ifdef RESET_SEQUENCER_CAUSE_EN
   logic [1:0] cause_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cause_q <= '0;
      end else if (req) begin
         if (state == RUN) begin
            cause_q <= {ext_req_i, sw_req_i};
         end else begin
            cause_q <= cause_q | {ext_req_i, sw_req_i};
         end
      end
   end

   assign rst_cause_o = cause_q;
`else
   assign rst_cause_o = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: default and minimum (1/1) configurations side by side.
module tb_reset_sequencer;

   localparam int H0 = 16;
   localparam int S0 = 8;
   localparam int H1 = 1;
   localparam int S1 = 1;

   logic       clk;
   logic       rst;
   logic       sw;
   logic       ext;
   logic       periph0, core0, busy0;
   logic [1:0] cause0;
   logic       periph1, core1, busy1;
   logic [1:0] cause1;

   int checks   = 0;
   int failures = 0;

   reset_sequencer #(.HOLD_CYCLES(H0), .STAGGER_CYCLES(S0)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .sw_req_i     (sw),
      .ext_req_i    (ext),
      .rst_periph_no(periph0),
      .rst_core_no  (core0),
      .busy_o       (busy0),
      .rst_cause_o  (cause0)
   );

   reset_sequencer #(.HOLD_CYCLES(H1), .STAGGER_CYCLES(S1)) dut_min (
      .clk_i        (clk),
      .rst_i        (rst),
      .sw_req_i     (sw),
      .ext_req_i    (ext),
      .rst_periph_no(periph1),
      .rst_core_no  (core1),
      .busy_o       (busy1),
      .rst_cause_o  (cause1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count quiet edges since the last reset/request; outputs follow from thresholds.
   int   quiet = 0;
   logic valid = 1'b0;
`ifdef RESET_SEQUENCER_CAUSE_EN
   logic [1:0] mc0 = 2'b00;
   logic [1:0] mc1 = 2'b00;
`endif

   always @(posedge clk) begin
      if (rst) begin
         quiet <= 0;
         valid <= 1'b1;
`ifdef RESET_SEQUENCER_CAUSE_EN
         mc0 <= 2'b00;
         mc1 <= 2'b00;
`endif
      end else if (sw || ext) begin
         quiet <= 0;
`ifdef RESET_SEQUENCER_CAUSE_EN
         mc0 <= (quiet >= H0 + S0) ? {ext, sw} : (mc0 | {ext, sw});
         mc1 <= (quiet >= H1 + S1) ? {ext, sw} : (mc1 | {ext, sw});
`endif
      end else if (quiet < 1000000) begin
         quiet <= quiet + 1;
      end
   end

   function automatic logic [1:0] exp_cause(input int which);
`ifdef RESET_SEQUENCER_CAUSE_EN
      return (which == 0) ? mc0 : mc1;
`else
      return (which == 0) ? 2'b00 : 2'b00;
`endif
   endfunction

   always @(negedge clk) begin
      if (valid) begin
         check("periph", 32'(periph0), 32'(quiet >= H0));
         check("core",   32'(core0),   32'(quiet >= H0 + S0));
         check("busy",   32'(busy0),   32'(quiet <  H0 + S0));
         check("cause",  32'(cause0),  32'(exp_cause(0)));
         check("periph_min", 32'(periph1), 32'(quiet >= H1));
         check("core_min",   32'(core1),   32'(quiet >= H1 + S1));
         check("busy_min",   32'(busy1),   32'(quiet <  H1 + S1));
         check("cause_min",  32'(cause1),  32'(exp_cause(1)));
      end
   end

`ifdef RESET_SEQUENCER_CAUSE_EN
   localparam logic [1:0] C_SW   = 2'b01;
   localparam logic [1:0] C_EXT  = 2'b10;
   localparam logic [1:0] C_BOTH = 2'b11;
`else
   localparam logic [1:0] C_SW   = 2'b00;
   localparam logic [1:0] C_EXT  = 2'b00;
   localparam logic [1:0] C_BOTH = 2'b00;
`endif

   // After the triggering edge, verify the 16 + 8 release pattern on the default instance.
   task automatic release_pattern(input string tag);
      repeat (15) @(negedge clk);
      check({tag, "_periph_e15"}, 32'(periph0), 32'd0);
      @(negedge clk);
      check({tag, "_periph_e16"}, 32'(periph0), 32'd1);
      check({tag, "_core_e16"},   32'(core0),   32'd0);
      repeat (7) @(negedge clk);
      check({tag, "_core_e23"},   32'(core0),   32'd0);
      @(negedge clk);
      check({tag, "_core_e24"},   32'(core0),   32'd1);
      check({tag, "_busy_e24"},   32'(busy0),   32'd0);
   endtask

   initial begin
      rst = 1'b1;
      sw  = 1'b0;
      ext = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_periph", 32'(periph0), 32'd0);
      check("reset_core",   32'(core0),   32'd0);
      check("reset_busy",   32'(busy0),   32'd1);
      check("reset_cause",  32'(cause0),  32'd0);
      rst = 1'b0;

      // Minimum configuration: periph after edge 1, core after edge 2.
      @(negedge clk);
      check("min_periph_e1", 32'(periph1), 32'd1);
      check("min_core_e1",   32'(core1),   32'd0);
      @(negedge clk);
      check("min_core_e2",   32'(core1),   32'd1);
      check("min_busy_e2",   32'(busy1),   32'd0);
      repeat (13) @(negedge clk);
      check("por_periph_e15", 32'(periph0), 32'd0);
      @(negedge clk);
      check("por_periph_e16", 32'(periph0), 32'd1);
      repeat (7) @(negedge clk);
      check("por_core_e23", 32'(core0), 32'd0);
      @(negedge clk);
      check("por_core_e24", 32'(core0), 32'd1);
      check("por_busy_e24", 32'(busy0), 32'd0);

      // Software pulse in RUN.
      repeat (3) @(negedge clk);
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      check("sw_periph_low", 32'(periph0), 32'd0);
      check("sw_core_low",   32'(core0),   32'd0);
      check("sw_cause",      32'(cause0),  32'(C_SW));
      release_pattern("sw");

      // External pulse on quiet edge 20 after a reset, i.e. during STAGGER.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (19) @(negedge clk);
      check("stag_periph_before", 32'(periph0), 32'd1);
      ext = 1'b1;
      @(negedge clk);
      ext = 1'b0;
      check("stag_periph_reassert", 32'(periph0), 32'd0);
      check("stag_cause",           32'(cause0),  32'(C_EXT));
      release_pattern("stag");

      // Both requests together in RUN.
      repeat (2) @(negedge clk);
      sw  = 1'b1;
      ext = 1'b1;
      @(negedge clk);
      sw  = 1'b0;
      ext = 1'b0;
      check("both_cause", 32'(cause0), 32'(C_BOTH));
      release_pattern("both");

      // Reset dominates a concurrent request.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      sw  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sw  = 1'b0;
      check("dom_cause",  32'(cause0),  32'd0);
      check("dom_periph", 32'(periph0), 32'd0);
      check("dom_core",   32'(core0),   32'd0);
      release_pattern("dom");

      // Held request keeps HOLD; then re-triggers in HOLD and STAGGER accumulate cause.
      sw = 1'b1;
      repeat (40) @(negedge clk);
      check("held_periph", 32'(periph0), 32'd0);
      sw = 1'b0;
      release_pattern("held");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      repeat (18) @(negedge clk);
      ext = 1'b1;
      @(negedge clk);
      ext = 1'b0;
      check("accum_cause", 32'(cause0), 32'(C_BOTH));
      release_pattern("accum");
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16: cycles both reset outputs stay asserted after any reset event; legal range 1..65535.
REQ-002 The block SHALL have parameter STAGGER_CYCLES, default 8: cycles between peripheral release and core release; legal range 1..65535.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sw_req_i, input, 1 bit: software reset request, level-sampled every cycle.
REQ-006 The block SHALL have port ext_req_i, input, 1 bit: external or watchdog reset request, synchronous to clk_i, level-sampled.
REQ-007 The block SHALL have port rst_periph_no, output, 1 bit: active-low peripheral reset (I2C, UART), registered.
REQ-008 The block SHALL have port rst_core_no, output, 1 bit: active-low core/accelerator reset, registered.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while the sequence is in progress (any state other than RUN).
REQ-010 The block SHALL have port rst_cause_o, output, 2 bits: cause of the last reset event; 00 = rst_i, 01 = sw, 10 = ext, 11 = sw and ext together.

Function
REQ-011 The FSM SHALL have exactly three states: HOLD, STAGGER and RUN.
REQ-012 Outputs per state SHALL be: HOLD gives periph=0, core=0, busy=1; STAGGER gives periph=1, core=0, busy=1; RUN gives periph=1, core=1, busy=0.
REQ-013 Edge 1 is the first rising edge with rst_i low. With no requests, rst_periph_no SHALL rise after edge HOLD_CYCLES and rst_core_no SHALL rise after edge HOLD_CYCLES+STAGGER_CYCLES.
REQ-014 A single down-counter, sized for max(HOLD_CYCLES, STAGGER_CYCLES), SHALL load the duration on state entry and SHALL transition when it reaches 1. No wrap-around is permitted.
REQ-015 In RUN, sw_req_i or ext_req_i high at an edge SHALL move the FSM to HOLD at that edge, so both outputs are low from the next cycle. Request-to-assert latency is 1 cycle.
REQ-016 A request in HOLD SHALL reload the HOLD counter, extending the hold. A request in STAGGER SHALL return the FSM to HOLD, reasserting rst_periph_no.
REQ-017 A request held high continuously SHALL keep the FSM in HOLD indefinitely. Release timing SHALL be measured from the first edge with both requests low.
REQ-018 rst_i SHALL dominate all requests at the same edge.
REQ-019 Outputs SHALL be glitch-free: driven directly from flops, with no combinational path from any input.

Reset
REQ-020 rst_i high at an edge SHALL force state HOLD, load the counter with HOLD_CYCLES, drive rst_periph_no=0, rst_core_no=0, busy_o=1 and rst_cause_o=00. This SHALL hold regardless of the current state, including mid-sequence.
REQ-021 The block SHALL NOT use asynchronous reset logic. Downstream reset_synchronizer instances in other clock domains consume rst_periph_no and rst_core_no.

Configuration
REQ-022 Macro RESET_SEQUENCER_CAUSE_EN SHALL control the cause register.
REQ-023 With RESET_SEQUENCER_CAUSE_EN defined, rst_cause_o SHALL be a register updated only on the edge that enters HOLD from a request: 01 for sw, 10 for ext, 11 for both at that edge.
REQ-024 Under RESET_SEQUENCER_CAUSE_EN, a re-trigger during HOLD or STAGGER SHALL OR the new cause bits into the register. The value SHALL be held until the next rst_i or the next RUN-to-HOLD transition.
REQ-025 Without RESET_SEQUENCER_CAUSE_EN, rst_cause_o SHALL be constant 2'b00, with no cause flops synthesised.

Verification
REQ-026 Defaults; rst_i high 3 cycles then low -> periph rises after edge 16, core after edge 24, busy_o falls with core.
REQ-027 In RUN, sw_req_i pulsed 1 cycle -> both outputs low the next cycle; periph high 16 cycles later, core 8 after that; cause=01 (macro on).
REQ-028 ext_req_i pulsed during STAGGER at cycle 20 -> periph reasserted next cycle; full 16+8 sequence restarts; cause=10 (macro on).
REQ-029 sw_req_i and ext_req_i high on the same edge in RUN -> cause=11 (macro on), or 00 (macro off).
REQ-030 rst_i asserted in RUN concurrent with sw_req_i -> cause=00, outputs low, timing per REQ-013.
REQ-031 HOLD_CYCLES=1, STAGGER_CYCLES=1 -> periph rises after edge 1, core after edge 2, with no counter underflow.
